// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// led_pattern_gen : WIDTH-bit LED animator (fill/dot/centre/bounce), prescaled.
// Macro LED_PATTERN_BOUNCE_EN enables bounce on mode 3; otherwise mode 3 = DOT.
// Revision: 1.0
// ============================================================================
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  localparam int               CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int               HALF    = WIDTH / 2;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] LED_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_MSB = LED_LSB << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LED_ALL = '1;
  localparam logic [WIDTH-1:0] CTR_IN  = (LED_LSB << HALF) | (LED_LSB << (HALF - 1));
  localparam logic [WIDTH-1:0] CTR_OUT = LED_MSB | LED_LSB;
  localparam logic [1:0]       M_FILL  = 2'd0;
  localparam logic [1:0]       M_CTR   = 2'd2;
  localparam logic [1:0]       M_BNC   = 2'd3;

  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] pat;
  logic             pat_wrap;
  logic             chg;
  logic [HALF-1:0]  up_s;
  logic [HALF-1:0]  lo_s;
`ifdef LED_PATTERN_BOUNCE_EN
  logic             bdir;
  logic             bdir_nxt;
`endif

  // A dir change only restarts patterns that actually use dir.
  always_comb begin
`ifdef LED_PATTERN_BOUNCE_EN
    chg = (mode != mode_q) || ((dir != dir_q) && (mode != M_BNC));
`else
    chg = (mode != mode_q) || (dir != dir_q);
`endif
  end

  always_comb begin
    pat      = led;
    pat_wrap = 1'b0;
    up_s     = '0;
    lo_s     = '0;
`ifdef LED_PATTERN_BOUNCE_EN
    bdir_nxt = bdir;
`endif
    case (mode_q)
      M_FILL: begin
        if (led == LED_ALL) begin
          pat      = '0;
          pat_wrap = 1'b1;
        end else begin
          pat = dir_q ? ((led >> 1) | LED_MSB) : ((led << 1) | LED_LSB);
        end
      end
      M_CTR: begin
        if (led == '0) begin
          pat = dir_q ? CTR_IN : CTR_OUT;
        end else begin
          // Halves shift independently so bits never cross the centre.
          up_s     = dir_q ? (led[WIDTH-1:HALF] << 1) : (led[WIDTH-1:HALF] >> 1);
          lo_s     = dir_q ? (led[HALF-1:0] >> 1) : (led[HALF-1:0] << 1);
          pat      = {up_s, lo_s};
          pat_wrap = ({up_s, lo_s} == '0);
        end
      end
`ifdef LED_PATTERN_BOUNCE_EN
      M_BNC: begin
        if (led == '0) begin
          pat = LED_LSB;
        end else begin
          pat      = bdir ? (led >> 1) : (led << 1);
          pat_wrap = ((bdir ? (led >> 1) : (led << 1)) == LED_LSB);
        end
        if (pat == LED_MSB) begin
          bdir_nxt = 1'b1;
        end else if (pat == LED_LSB) begin
          bdir_nxt = 1'b0;
        end
      end
`endif
      default: begin
        if (led == '0) begin
          pat = dir_q ? LED_MSB : LED_LSB;
        end else begin
          pat      = dir_q ? (led >> 1) : (led << 1);
          pat_wrap = ((dir_q ? (led >> 1) : (led << 1)) == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || chg) begin
      led    <= '0;
      wrap   <= 1'b0;
      cnt    <= '0;
      mode_q <= mode;
      dir_q  <= dir;
`ifdef LED_PATTERN_BOUNCE_EN
      bdir   <= 1'b0;
`endif
    end else if (!ss) begin
      wrap <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      led  <= pat;
      wrap <= pat_wrap;
`ifdef LED_PATTERN_BOUNCE_EN
      bdir <= bdir_nxt;
`endif
    end else begin
      cnt  <= cnt + CNT_ONE;
      wrap <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// tb_led_pattern_gen : two instances (DIV=1, DIV=3) checked every cycle against
// a sequence-index model, plus directed literal expectations.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] led1, led3;
  logic       wrap1, wrap3;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

`ifdef LED_PATTERN_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(8), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .ss(ss), .mode(mode), .dir(dir), .led(led1), .wrap(wrap1)
  );
  led_pattern_gen #(.WIDTH(8), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .ss(ss), .mode(mode), .dir(dir), .led(led3), .wrap(wrap3)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  // Model: each pattern is a sequence indexed by k; k=0 is blank.
  int         m_div [2] = '{1, 3};
  int         m_k   [2];
  int         m_cnt [2];
  logic [1:0] m_mode[2];
  logic       m_dir [2];
  logic [7:0] m_led [2];
  logic       m_wrap[2];

  function automatic int period(input logic [1:0] em);
    return (em == 2'd2) ? 5 : 9;
  endfunction

  function automatic logic [7:0] led_of(input logic [1:0] em, input logic d, input int k);
    logic [7:0] ones;
    logic [7:0] one;
    ones = 8'hFF;
    one  = 8'h01;
    if (k == 0) return 8'h00;
    case (em)
      2'd0:    return d ? ~(ones >> k) : ~(ones << k);
      2'd1:    return d ? ((one << 7) >> (k - 1)) : (one << (k - 1));
      2'd2:    return d ? ((one << (3 + k)) | (one << (4 - k)))
                        : ((one << (8 - k)) | (one << (k - 1)));
      default: return one << ((k <= 8) ? (k - 1) : (15 - k));
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] em;
    logic       chg;
    for (int i = 0; i < 2; i++) begin
      chg = (mode != m_mode[i]) || ((dir != m_dir[i]) && !(BOUNCE && mode == 2'd3));
      if (rst || chg) begin
        m_k[i] = 0; m_cnt[i] = 0; m_mode[i] = mode; m_dir[i] = dir;
        m_led[i] = 8'h00; m_wrap[i] = 1'b0;
      end else if (!ss) begin
        m_wrap[i] = 1'b0;
      end else if (m_cnt[i] == m_div[i] - 1) begin
        m_cnt[i] = 0;
        em = (m_mode[i] == 2'd3 && !BOUNCE) ? 2'd1 : m_mode[i];
        if (em == 2'd3) begin
          m_wrap[i] = (m_k[i] == 14);
          m_k[i]    = (m_k[i] == 14) ? 1 : m_k[i] + 1;
        end else begin
          m_k[i]    = (m_k[i] + 1) % period(em);
          m_wrap[i] = (m_k[i] == 0);
        end
        m_led[i] = led_of(em, m_dir[i], m_k[i]);
      end else begin
        m_cnt[i]  = m_cnt[i] + 1;
        m_wrap[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      check("model_led1", led1, m_led[0]);
      check("model_wrap1", {7'd0, wrap1}, {7'd0, m_wrap[0]});
      check("model_led3", led3, m_led[1]);
      check("model_wrap3", {7'd0, wrap3}, {7'd0, m_wrap[1]});
    end
  end

  logic [7:0] fill_t [9]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
  logic [7:0] ctro_t [6]  = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00, 8'h18};
  logic [7:0] ctri_t [5]  = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00};
`ifdef LED_PATTERN_BOUNCE_EN
  localparam int M3_N = 16;
  localparam int M3_W = 14;
  logic [7:0] m3_t [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`else
  localparam int M3_N = 10;
  localparam int M3_W = 8;
  logic [7:0] m3_t [10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                            8'h00, 8'h80};
`endif

  initial begin
    rst = 1'b1; ss = 1'b0; mode = 2'd0; dir = 1'b1;
    adv(); adv();
    run_chk = 1'b1;
    check("rst_led1", led1, 8'h00);
    check("rst_wrap1", {7'd0, wrap1}, 8'h00);
    check("rst_led3", led3, 8'h00);

    // FILL toward LSB, one step per cycle
    rst = 1'b0; ss = 1'b1;
    for (int i = 0; i < 9; i++) begin
      adv();
      check("fill_led", led1, fill_t[i]);
      check("fill_wrap", {7'd0, wrap1}, {7'd0, (i == 8)});
    end

    // DOT toward MSB with DIV=3, freeze mid-count
    mode = 2'd1; dir = 1'b0;
    adv();
    check("dot_clr", led3, 8'h00);
    adv(); adv();
    check("dot_pre", led3, 8'h00);
    adv();
    check("dot_1st", led3, 8'h01);
    adv(); adv(); adv();
    check("dot_2nd", led3, 8'h02);
    adv();
    ss = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv();
      check("dot_frz", led3, 8'h02);
    end
    ss = 1'b1;
    adv();
    check("dot_res", led3, 8'h02);
    adv();
    check("dot_3rd", led3, 8'h04);

    // CENTER outward then inward
    mode = 2'd2; dir = 1'b1;
    adv();
    check("ctr_clr", led1, 8'h00);
    for (int i = 0; i < 6; i++) begin
      adv();
      check("ctr_out", led1, ctro_t[i]);
      check("ctr_out_wrap", {7'd0, wrap1}, {7'd0, (i == 4)});
    end
    dir = 1'b0;
    adv();
    check("ctr_dclr", led1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      adv();
      check("ctr_in", led1, ctri_t[i]);
      check("ctr_in_wrap", {7'd0, wrap1}, {7'd0, (i == 4)});
    end

    // Mode 3: bounce, or DOT when the bounce build is off
    mode = 2'd3; dir = 1'b1;
    adv();
    for (int i = 0; i < M3_N; i++) begin
      adv();
      check("m3_led", led1, m3_t[i]);
      check("m3_wrap", {7'd0, wrap1}, {7'd0, (i == M3_W)});
    end
    dir = 1'b0;
    for (int i = 0; i < 6; i++) adv();
    dir = 1'b1;
    for (int i = 0; i < 4; i++) adv();

    // Mode switch mid-pattern, then reset mid-pattern
    mode = 2'd1; dir = 1'b0;
    adv();
    for (int i = 0; i < 5; i++) adv();
    check("sw_pre", led1, 8'h10);
    mode = 2'd2;
    adv();
    check("sw_clr1", led1, 8'h00);
    check("sw_clr3", led3, 8'h00);
    adv(); adv();
    check("sw_cnt3", led3, 8'h00);
    adv();
    check("sw_step3", led3, 8'h81);
    check("sw_u1", led1, 8'h24);
    adv();
    check("pre_rst", led1, 8'h18);
    rst = 1'b1;
    adv();
    check("rst_mid_led", led1, 8'h00);
    check("rst_mid_wrap", {7'd0, wrap1}, 8'h00);
    check("rst_mid_led3", led3, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) adv();

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator driving a WIDTH-bit LED bank from one clock. Four selectable animations (fill, single dot, centre in/out, bounce) advance at a programmable rate set by an internal prescaler. The block sits between the board clock/switch inputs and the LED pins. It replaces the fixed 8-bit single-pattern shifters with one configurable unit.

## Interface
Parameters:
- WIDTH, 8, LED count; even, ≥4
- DIV, 4, clock cycles per animation step; ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- ss  in  1  run enable (1 = animate, 0 = freeze)
- mode  in  2  pattern select: 0 FILL, 1 DOT, 2 CENTER, 3 BOUNCE
- dir  in  1  direction: 1 = MSB→LSB / outward, 0 = LSB→MSB / inward; ignored in BOUNCE
- led  out  WIDTH  LED drive, registered
- wrap  out  1  one-cycle pulse on the step that completes a pattern cycle

## Operation
- Registered state:
  - led
  - prescaler cnt (0..DIV-1)
  - mode_q, dir_q (last accepted mode/dir)
  - bdir (bounce direction; 0 = toward MSB)
  - wrap
- Step condition: ss=1 and cnt==DIV-1. cnt then returns to 0; otherwise, with ss=1, cnt increments.
- ss=0: led, cnt, bdir hold; wrap=0.
- Mode or dir change (mode≠mode_q, or dir≠dir_q while mode≠3), checked every cycle regardless of ss:
  - next edge: led=0, cnt=0, bdir=0, wrap=0, mode_q/dir_q updated
  - no step taken that cycle
- FILL:
  - dir=1: led = (led>>1) | MSB
  - dir=0: led = (led<<1) | 1
  - led all-ones → next step led=0, wrap=1
- DOT:
  - led=0 → load MSB (dir=1) or LSB (dir=0)
  - otherwise shift right (dir=1) or left (dir=0), zero fill
  - The step that shifts the bit out gives led=0 and wrap=1.
- CENTER: upper half U=led[W-1:W/2] and lower half L=led[W/2-1:0] shift independently; no bit crosses between halves.
  - led=0, dir=1 → load bits W/2 and W/2-1
  - led=0, dir=0 → load bits W-1 and 0
  - dir=1: U<<1, L>>1
  - dir=0: U>>1, L<<1
  - Step producing 0 asserts wrap.
- BOUNCE: a single dot that never blanks.
  - led=0 → load LSB
  - bdir=0 → shift left; bdir=1 → shift right
  - Reaching MSB sets bdir=1; reaching LSB sets bdir=0. The reversal takes effect on the following step.
  - wrap=1 on the step that lands the dot on LSB.
- Any led value outside the current pattern's sequence cannot occur; only reset and mode/dir change load led.

## Timing
- Reset values: led=0, wrap=0, cnt=0, bdir=0, mode_q=mode, dir_q=dir.
- rst has priority over everything, mid-pattern included.
- First step lands DIV edges after ss rises from reset (DIV=1: next edge).
- led and wrap update on the same edge; wrap high exactly one cycle.
- Period per mode, in steps:
  - FILL: WIDTH+1
  - DOT: WIDTH+1
  - CENTER: WIDTH/2+1
  - BOUNCE: 2·(WIDTH-1)
- Mode/dir change coinciding with a step: the clear wins, and the step is discarded.
- ss dropping mid-count freezes cnt; resuming continues from the held count.

## Configuration
- LED_PATTERN_BOUNCE_EN:
  - Defined: mode 3 = BOUNCE as above; bdir register present.
  - Undefined: bdir is removed and mode 3 behaves exactly as DOT, including dir and wrap.

## Test plan
- WIDTH=8, DIV=1, mode=0, dir=1, ss=1 after reset → led sequence 00,80,C0,E0,F0,F8,FC,FE,FF,00; wrap only on the FF→00 step.
- WIDTH=8, DIV=3, mode=1, dir=0 → led 01 after 3 cycles, 02 after 6; ss=0 for 5 cycles → led and cnt frozen; resume keeps 3-cycle spacing.
- WIDTH=8, DIV=1, mode=2, dir=1 → 18,24,42,81,00 repeating; dir=0 → 81,42,24,18,00.
- WIDTH=8, DIV=1, mode=3 → 01,02,…,80,40,…,01; wrap on each return to 01.
  - Repeat with LED_PATTERN_BOUNCE_EN undefined and dir=1 → DOT sequence 80,40,…,01,00.
- Mode switch 1→2 while led=10 → next edge led=00, cnt=0; rst pulsed mid-pattern → led=00, wrap=0 on that edge.
